// File: rtl/seg_pkg.sv
// Shared glyph constants and FSM state type for the 7-segment scan controller.
package seg_pkg;

    // Active-high glyphs, bit order gfedcba.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble + decimal point to active-high segment glyph.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] glyph_o
);

    logic [7:0] base;

    always_comb begin
        base = SEG_BLANK;
        case (nibble_i)
            4'h0:    base = SEG_0;
            4'h1:    base = SEG_1;
            4'h2:    base = SEG_2;
            4'h3:    base = SEG_3;
            4'h4:    base = SEG_4;
            4'h5:    base = SEG_5;
            4'h6:    base = SEG_6;
            4'h7:    base = SEG_7;
            4'h8:    base = SEG_8;
            4'h9:    base = SEG_9;
            4'hF:    base = SEG_DASH;
            default: base = SEG_BLANK;
        endcase
        glyph_o = {dp_i, 7'b0} | base;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller: value handshake, blank/drive FSM,
// 16-step PWM brightness and registered active-low pin outputs.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 16000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [3:0]  bright,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig,
    output logic        frame_start
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            pend_full_q;
    logic [15:0]     pend_val_q, act_val_q;
    logic [3:0]      pend_dp_q, act_dp_q;

    logic [7:0]      seg_q, seg_d;
    logic [3:0]      dig_q, dig_d;
    logic            fs_q, fs_d;

    logic            boundary;
    logic            xfer;
    logic [7:0]      glyph;

    assign value_ready = ~pend_full_q;
    assign xfer        = value_valid && value_ready;
    assign boundary    = (state_q == ST_BLANK) && (idx_q == 2'd0) && (cnt_q == '0);

    seg_decode u_decode (
        .nibble_i (act_val_q[idx_q*4 +: 4]),
        .dp_i     (act_dp_q[idx_q]),
        .glyph_o  (glyph)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        if (state_q == ST_BLANK) begin
            if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                state_d = ST_DRIVE;
                cnt_d   = '0;
            end
        end else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
            state_d = ST_BLANK;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
        end
    end

    // Outputs are a registered image of the current FSM cycle.
    always_comb begin
        dig_d = '0;
        seg_d = '1;
        fs_d  = boundary;
        if (state_q == ST_DRIVE) begin
            dig_d = 4'b0001 << idx_q;
            if (cnt_q[3:0] <= bright)
                seg_d = ~glyph;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            seg_q       <= '1;
            dig_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fs_q    <= fs_d;
            // Copy and load are exclusive: a full slot deasserts ready.
            if (boundary && pend_full_q) begin
                act_val_q   <= pend_val_q;
                act_dp_q    <= pend_dp_q;
                pend_full_q <= 1'b0;
            end else if (xfer) begin
                pend_val_q  <= value;
                pend_dp_q   <= dp;
                pend_full_q <= 1'b1;
            end
        end
    end

    assign seg_n       = seg_q;
    assign dig         = dig_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;
    localparam int unsigned DP = DW + BL;
    localparam int unsigned FR = 4 * DP;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic [3:0]  bright = 4'hF;
    logic [7:0]  seg_n;
    logic [3:0]  dig;
    logic        frame_start;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    seg_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .value       (value),
        .dp          (dp),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .bright      (bright),
        .seg_n       (seg_n),
        .dig         (dig),
        .frame_start (frame_start)
    );

    always #5 CLK = ~CLK;

    logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};

    // Reference state: cycles since reset release plus the two data slots.
    int unsigned s;
    logic [15:0] m_act_val, m_pend_val;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_full;
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_fs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, s, got, exp);
        end
    endtask

    task automatic model_reset();
        s          = 0;
        m_act_val  = '0;
        m_act_dp   = '0;
        m_pend_val = '0;
        m_pend_dp  = '0;
        m_full     = 1'b0;
        e_seg      = 8'hFF;
        e_dig      = 4'h0;
        e_fs       = 1'b0;
    endtask

    // Called at a falling edge: check pins, drive this cycle's inputs, advance model.
    task automatic step(input logic v, input logic [15:0] val, input logic [3:0] d, input logic [3:0] b);
        int unsigned p, dg, o, c;
        logic [3:0]  nib;
        logic [7:0]  g;
        check_eq("seg_n", 32'(seg_n), 32'(e_seg));
        check_eq("dig", 32'(dig), 32'(e_dig));
        check_eq("frame_start", 32'(frame_start), 32'(e_fs));
        check_eq("value_ready", 32'(value_ready), 32'(!m_full));

        value_valid = v;
        value       = val;
        dp          = d;
        bright      = b;

        p  = s % FR;
        dg = p / DP;
        o  = p % DP;
        e_fs = (p == 0);
        if (o < BL) begin
            e_dig = 4'h0;
            e_seg = 8'hFF;
        end else begin
            c     = o - BL;
            e_dig = 4'(1 << dg);
            nib   = m_act_val[4*dg +: 4];
            g     = glyph[nib] | (m_act_dp[dg] ? 8'h80 : 8'h00);
            e_seg = ((c % 16) <= 32'(b)) ? ~g : 8'hFF;
        end

        if (p == 0 && m_full) begin
            m_act_val = m_pend_val;
            m_act_dp  = m_pend_dp;
            m_full    = 1'b0;
        end else if (v && !m_full) begin
            m_pend_val = val;
            m_pend_dp  = d;
            m_full     = 1'b1;
        end

        @(negedge CLK);
        s++;
    endtask

    task automatic rand_steps(input int unsigned n, input int unsigned valid_div);
        logic [3:0] b;
        b = bright;
        for (int i = 0; i < int'(n); i++) begin
            if ($urandom_range(29) == 0) b = 4'($urandom_range(15));
            step(($urandom_range(valid_div - 1) == 0), 16'($urandom), 4'($urandom), b);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        check_eq("rst_seg_n", 32'(seg_n), 32'h0FF);
        check_eq("rst_dig", 32'(dig), 32'h0);
        check_eq("rst_frame_start", 32'(frame_start), 32'h0);
        check_eq("rst_value_ready", 32'(value_ready), 32'h1);
        RST_N = 1'b1;

        for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 4'h0, 4'hF);

        step(1'b1, 16'h4321, 4'b0100, 4'hF);
        for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 4'h0, 4'hF);

        step(1'b1, 16'h1234, 4'h0, 4'hF);
        for (int i = 0; i < 200; i++) step(1'b1, 16'h5678, 4'h0, 4'hF);
        for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 4'h0, 4'hF);

        step(1'b1, 16'h9876, 4'b1010, 4'h3);
        for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 4'h0, 4'h3);

        step(1'b1, 16'hFA09, 4'h0, 4'hF);
        for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 4'h0, 4'hF);

        step(1'b0, 16'h0, 4'h0, 4'h0);
        rand_steps(1500, 20);

        // Reset asserted mid-dwell of digit 2.
        for (int i = 0; i < int'(FR) && (s % FR) != 2 * DP + 10; i++) step(1'b0, 16'h0, 4'h0, 4'hF);
        check_eq("pre_rst_dig", 32'(dig), 32'h4);
        value_valid = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        check_eq("async_rst_seg_n", 32'(seg_n), 32'h0FF);
        check_eq("async_rst_dig", 32'(dig), 32'h0);
        check_eq("async_rst_frame_start", 32'(frame_start), 32'h0);
        check_eq("async_rst_value_ready", 32'(value_ready), 32'h1);
        @(negedge CLK);
        @(negedge CLK);
        model_reset();
        RST_N = 1'b1;
        for (int i = 0; i < 160; i++) step(1'b0, 16'h0, 4'h0, 4'hF);
        rand_steps(400, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
